// File: rtl/bec_pkg.sv
// bec_pkg: shared types and defaults for the binary-Edwards-curve ladder sequencer
package bec_pkg;
    localparam int KEY_BITS_DEFAULT = 163;
    localparam int TIMEOUT_DEFAULT  = 1024;
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INIT  = 4'd1,
        S_ISSUE = 4'd2,
        S_WAIT  = 4'd3,
        S_SHIFT = 4'd4,
        S_FINAL = 4'd5,
        S_FWAIT = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;
endpackage

// File: rtl/bec_ladder_ctrl_if.sv
// bec_ladder_ctrl_if: front-end and datapath handshake bundle of the ladder sequencer
interface bec_ladder_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             ena_proc;
    logic             ki;
    logic             step_done;
    logic             final_done;
    logic             load_init;
    logic             step_start;
    logic             step_kbit;
    logic             cswap;
    logic             next_key;
    logic             final_start;
    logic             final_swap;
    logic             slv_done;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] iter_cnt;
    modport master (
        output ena_proc, ki, step_done, final_done,
        input  load_init, step_start, step_kbit, cswap, next_key, final_start,
        input  final_swap, slv_done, busy, err, iter_cnt
    );
    modport slave (
        input  ena_proc, ki, step_done, final_done,
        output load_init, step_start, step_kbit, cswap, next_key, final_start,
        output final_swap, slv_done, busy, err, iter_cnt
    );
endinterface

// File: rtl/bec_step_watchdog.sv
// bec_step_watchdog: counts waiting cycles and flags the cycle that would reach TIMEOUT
module bec_step_watchdog
    import bec_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int TO_W    = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_timeout
);
    logic [TO_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst || i_clear)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end
    assign o_timeout = i_en && (r_cnt == TO_W'(TIMEOUT - 1));
endmodule

// File: rtl/bec_ladder_ctrl.sv
// bec_ladder_ctrl: one ladder step per key bit, conditional-swap control, final conversion, watchdog
module bec_ladder_ctrl
    import bec_pkg::*;
#(
    parameter int KEY_BITS = KEY_BITS_DEFAULT,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = TIMEOUT_DEFAULT,
    parameter int TO_W     = 11
) (
    input logic              wb_clk_i,
    input logic              wb_rst_i,
    bec_ladder_ctrl_if.slave bus
);
    state_t           r_state, w_next;
    logic             r_kprev, r_step_kbit, r_cswap, r_final_swap;
    logic [CNT_W-1:0] r_iter_cnt, w_cnt_inc;
    logic             w_run, w_abort, w_wd_clear, w_wd_en, w_timeout;

    assign w_run      = !(r_state inside {S_IDLE, S_DONE, S_ERR});
    assign w_abort    = w_run && !bus.ena_proc;
    assign w_cnt_inc  = r_iter_cnt + 1'b1;
    assign w_wd_clear = r_state inside {S_IDLE, S_ISSUE, S_FINAL};
    assign w_wd_en    = (r_state == S_WAIT && !bus.step_done) || (r_state == S_FWAIT && !bus.final_done);

    bec_step_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wd (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_clear   (w_wd_clear),
        .i_en      (w_wd_en),
        .o_timeout (w_timeout)
    );

    always_comb begin
        w_next = r_state;
        if (w_abort)
            w_next = S_IDLE;
        else
            case (r_state)
                S_IDLE:  w_next = bus.ena_proc ? S_INIT : S_IDLE;
                S_INIT:  w_next = S_ISSUE;
                S_ISSUE: w_next = S_WAIT;
                S_WAIT:  w_next = bus.step_done ? ((w_cnt_inc == CNT_W'(KEY_BITS)) ? S_FINAL : S_SHIFT)
                                                : (w_timeout ? S_ERR : S_WAIT);
                S_SHIFT: w_next = S_ISSUE;
                S_FINAL: w_next = S_FWAIT;
                S_FWAIT: w_next = bus.final_done ? S_DONE : (w_timeout ? S_ERR : S_FWAIT);
                S_DONE:  w_next = bus.ena_proc ? S_DONE : S_IDLE;
                S_ERR:   w_next = bus.ena_proc ? S_ERR : S_IDLE;
                default: w_next = S_IDLE;
            endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= S_IDLE;
            r_kprev      <= 1'b0;
            r_step_kbit  <= 1'b0;
            r_cswap      <= 1'b0;
            r_final_swap <= 1'b0;
            r_iter_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                r_iter_cnt <= '0;
                r_kprev    <= 1'b0;
            end
            if (r_state == S_ISSUE) begin
                r_step_kbit <= bus.ki;
                r_cswap     <= bus.ki ^ r_kprev;
                r_kprev     <= bus.ki;
            end
            if (r_state == S_WAIT && bus.step_done && !w_abort)
                r_iter_cnt <= w_cnt_inc;
            if (r_state == S_FINAL)
                r_final_swap <= r_kprev;
        end
    end

    assign bus.load_init   = (r_state == S_INIT);
    assign bus.step_start  = (r_state == S_ISSUE);
    assign bus.next_key    = (r_state == S_SHIFT);
    assign bus.final_start = (r_state == S_FINAL);
    assign bus.slv_done    = (r_state == S_DONE);
    assign bus.err         = (r_state == S_ERR);
    assign bus.busy        = w_run;
    assign bus.step_kbit   = r_step_kbit;
    assign bus.cswap       = r_cswap;
    assign bus.final_swap  = r_final_swap;
    assign bus.iter_cnt    = r_iter_cnt;
endmodule
